pong_match_controller: RTL and testbench
========================================

Name: pong_match_controller

Overview:
- Top-level match sequencer for the Pong game.
- Holds the ball controller in reset between rallies and drives its active-low reset.
- Watches the ball position to decide paddle hits versus misses, and keeps both scores.
- Declares the winner. Sits between the button and paddle logic and the ball/VGA datapath.

Parameters:
- GAME_WIDTH, 40, board width in game units; the right wall column is GAME_WIDTH-1.
- GAME_HEIGHT, 30, board height in game units.
- PADDLE_HEIGHT, 6, paddle length in units, measured downward from paddle_y.
- SERVE_TICKS, 25000000, clock cycles the ball is held centred before each serve (1 s at 25 MHz).
- WIN_SCORE, 9, score that ends the match (1..15).

Ports:
- clock  in  1  system clock, 25 MHz.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level start button (debounced upstream).
- ball_x  in  6  current ball column from the ball controller.
- ball_y  in  6  current ball row from the ball controller.
- p1_paddle_y  in  6  top row of the left paddle (column 0).
- p2_paddle_y  in  6  top row of the right paddle (column GAME_WIDTH-1).
- ball_reset_n  out  1  active-low reset to the ball controller.
- p1_score  out  4  left player score.
- p2_score  out  4  right player score.
- winner  out  2  0 = none, 1 = P1, 2 = P2.
- match_state  out  3  encoded FSM state, for the display.
- point_pulse  out  1  one-cycle pulse when a point is scored.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- On reset, the FSM goes to IDLE. Reset values: ball_reset_n=0, p1_score=0, p2_score=0, winner=0, point_pulse=0, serve counter=0, start edge register=0.
- Reset has priority in any state, including mid-rally and mid-serve.
- start_rise is start & ~start_q, with start_q registered. Only rising edges act.
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
- IDLE:
  - ball_reset_n=0.
  - start_rise: go to SERVE and clear the serve counter.
- SERVE:
  - ball_reset_n=0.
  - The counter increments each cycle. When it reaches SERVE_TICKS-1, go to PLAY.
  - On that same cycle, load prev_x/prev_y with ball_x/ball_y so PLAY sees no spurious step.
  - start_rise is ignored.
- PLAY:
  - ball_reset_n=1.
  - A step is detected when (ball_x,ball_y) != (prev_x,prev_y). On a step, update prev_x/prev_y.
  - Step with ball_x==0:
    - Hit if p1_paddle_y <= ball_y <= p1_top_end. Stay in PLAY.
    - Otherwise P2 scores: go to POINT with scorer=P2.
  - Step with ball_x==GAME_WIDTH-1: same check using p2_paddle_y; on a miss, scorer=P1.
  - Paddle end = paddle_y+PADDLE_HEIGHT-1, computed in 7 bits and saturated to GAME_HEIGHT-1.
  - start_rise is ignored.
  - Detection latency: the state changes one cycle after the ball input changes.
- POINT (one cycle):
  - ball_reset_n=0 and point_pulse=1.
  - Increment the scorer's score.
  - If the new score == WIN_SCORE: set winner and go to GAME_OVER.
  - Otherwise go to SERVE with the counter cleared.
  - Scores never exceed WIN_SCORE; there is no wrap.
- GAME_OVER:
  - ball_reset_n=0. Scores and winner hold.
  - start_rise: clear scores and winner, go to SERVE.
- Undefined state encodings return to IDLE on the next cycle.
- point_pulse is registered; it is high only in the cycle the FSM is in POINT.

Optional Feature:
- Macro PONG_RALLY_COUNT_EN.
- When defined:
  - Extra output rally_count [7:0], reset to 0.
  - Increments on each detected paddle hit, saturating at 255.
  - Clears to 0 in POINT and whenever the FSM enters SERVE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start held high 10 cycles (SERVE_TICKS=4 for sim) -> single SERVE entry; PLAY reached 4 cycles after the start edge; ball_reset_n rises on the PLAY entry cycle.
- PLAY, p1_paddle_y=10, ball steps to (0,12) -> stays PLAY, no point_pulse, scores 0/0.
- PLAY, p1_paddle_y=10, ball steps to (0,16) -> POINT one cycle later; point_pulse one cycle; p2_score=1; ball_reset_n=0; returns to SERVE.
- p2_paddle_y=27, ball steps to (39,29) -> hit (saturated end=29), no point. Same at (39,26) -> p1_score increments.
- p1_score=8 with WIN_SCORE=9, P2 misses -> p1_score=9, winner=1, GAME_OVER. Ball steps are then ignored; start edge -> scores 0, winner 0, SERVE.
- Reset asserted mid-SERVE and mid-PLAY with scores 3/5 -> next cycle: IDLE, scores 0/0, ball_reset_n=0. With PONG_RALLY_COUNT_EN: 3 hits -> rally_count=3, cleared on point.

Source files
------------

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve timing, hit/miss judging, scoring and winner.
// Latency: a miss is reflected in match_state one cycle after the ball input moves.
// Backpressure: none; the ball controller is held in reset outside of PLAY.
// Optional build macro: PONG_RALLY_COUNT_EN adds the rally_count output.
module pong_match_controller #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SERVE_TICKS   = 25000000,
  parameter int WIN_SCORE     = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] ball_x,
  input  logic [5:0] ball_y,
  input  logic [5:0] p1_paddle_y,
  input  logic [5:0] p2_paddle_y,
  output logic       ball_reset_n,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [2:0] match_state,
`ifdef PONG_RALLY_COUNT_EN
  output logic [7:0] rally_count,
`endif
  output logic       point_pulse
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Serve counter only needs to reach SERVE_TICKS-1.
  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
  localparam logic [5:0] RIGHT_COL = 6'(GAME_WIDTH - 1);
  localparam logic [6:0] BOTTOM_ROW = 7'(GAME_HEIGHT - 1);
  localparam logic [6:0] PAD_SPAN = 7'(PADDLE_HEIGHT - 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t state;
  state_t next_state;

  logic             start_q;
  logic             start_rise;
  logic [CNT_W-1:0] serve_cnt;
  logic [5:0]       prev_x;
  logic [5:0]       prev_y;
  logic             scorer_p2;

  logic [6:0] p1_end_raw;
  logic [6:0] p2_end_raw;
  logic [5:0] p1_end;
  logic [5:0] p2_end;
  logic       step;
  logic       p1_hit;
  logic       p2_hit;
  logic [3:0] p1_inc;
  logic [3:0] p2_inc;

  // Control strobes from the next-state logic.
  logic cnt_clr;
  logic prev_load;
  logic miss_evt;
  logic miss_by_p1;
  logic hit_evt;
  logic score_commit;
  logic scores_clr;

  assign start_rise = start & ~start_q;
  assign step = (ball_x != prev_x) || (ball_y != prev_y);

  // Paddle bottom row in 7 bits so a paddle near the floor cannot wrap.
  assign p1_end_raw = {1'b0, p1_paddle_y} + PAD_SPAN;
  assign p2_end_raw = {1'b0, p2_paddle_y} + PAD_SPAN;
  assign p1_end = (p1_end_raw > BOTTOM_ROW) ? BOTTOM_ROW[5:0] : p1_end_raw[5:0];
  assign p2_end = (p2_end_raw > BOTTOM_ROW) ? BOTTOM_ROW[5:0] : p2_end_raw[5:0];

  assign p1_hit = (ball_y >= p1_paddle_y) && (ball_y <= p1_end);
  assign p2_hit = (ball_y >= p2_paddle_y) && (ball_y <= p2_end);

  // Candidate scores after a point; never step past the winning score.
  assign p1_inc = (p1_score < WIN) ? p1_score + 4'd1 : p1_score;
  assign p2_inc = (p2_score < WIN) ? p2_score + 4'd1 : p2_score;

  assign match_state = state;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    next_state   = state;
    cnt_clr      = 1'b0;
    prev_load    = 1'b0;
    miss_evt     = 1'b0;
    miss_by_p1   = 1'b0;
    hit_evt      = 1'b0;
    score_commit = 1'b0;
    scores_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start_rise) begin
          next_state = SERVE;
          cnt_clr    = 1'b1;
        end
      end
      SERVE: begin
        if (serve_cnt == SERVE_LAST) begin
          next_state = PLAY;
          // Sync the step detector to the parked ball so PLAY starts quiet.
          prev_load  = 1'b1;
        end
      end
      PLAY: begin
        if (step) begin
          prev_load = 1'b1;
          if (ball_x == 6'd0) begin
            if (p1_hit) begin
              hit_evt = 1'b1;
            end else begin
              miss_evt   = 1'b1;
              miss_by_p1 = 1'b1;
              next_state = POINT;
            end
          end else if (ball_x == RIGHT_COL) begin
            if (p2_hit) begin
              hit_evt = 1'b1;
            end else begin
              miss_evt   = 1'b1;
              next_state = POINT;
            end
          end
        end
      end
      POINT: begin
        score_commit = 1'b1;
        if ((scorer_p2 ? p2_inc : p1_inc) == WIN) begin
          next_state = GAME_OVER;
        end else begin
          next_state = SERVE;
          cnt_clr    = 1'b1;
        end
      end
      GAME_OVER: begin
        if (start_rise) begin
          next_state = SERVE;
          cnt_clr    = 1'b1;
          scores_clr = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Start edge detector.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  // Serve hold counter: cleared on entry, free-runs while serving.
  always_ff @(posedge clock) begin
    if (reset) begin
      serve_cnt <= '0;
    end else if (cnt_clr) begin
      serve_cnt <= '0;
    end else if (state == SERVE) begin
      serve_cnt <= serve_cnt + 1'b1;
    end
  end

  // Last ball position seen, used to detect motion steps.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_x <= '0;
      prev_y <= '0;
    end else if (prev_load) begin
      prev_x <= ball_x;
      prev_y <= ball_y;
    end
  end

  // Remember who gets the point; consumed in the POINT cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      scorer_p2 <= 1'b0;
    end else if (miss_evt) begin
      scorer_p2 <= miss_by_p1;
    end
  end

  // Scores and winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_score <= '0;
      p2_score <= '0;
      winner   <= 2'd0;
    end else if (scores_clr) begin
      p1_score <= '0;
      p2_score <= '0;
      winner   <= 2'd0;
    end else if (score_commit) begin
      if (scorer_p2) begin
        p2_score <= p2_inc;
        if (p2_inc == WIN) winner <= 2'd2;
      end else begin
        p1_score <= p1_inc;
        if (p1_inc == WIN) winner <= 2'd1;
      end
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      ball_reset_n <= 1'b0;
      point_pulse  <= 1'b0;
    end else begin
      ball_reset_n <= (next_state == PLAY);
      point_pulse  <= (next_state == POINT);
    end
  end

`ifdef PONG_RALLY_COUNT_EN
  // Paddle-hit counter for the current rally, saturating at 255.
  always_ff @(posedge clock) begin
    if (reset) begin
      rally_count <= 8'd0;
    end else if ((state == POINT) || ((next_state == SERVE) && (state != SERVE))) begin
      rally_count <= 8'd0;
    end else if (hit_evt && (rally_count != 8'hFF)) begin
      rally_count <= rally_count + 8'd1;
    end
  end
`else
  logic unused_hit;
  assign unused_hit = hit_evt;
`endif

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller with a 4-cycle serve hold.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Expected values are hand-derived from the match rules.
module tb_pong_match_controller;

  logic       clock;
  logic       reset;
  logic       start;
  logic [5:0] ball_x;
  logic [5:0] ball_y;
  logic [5:0] p1_paddle_y;
  logic [5:0] p2_paddle_y;
  logic       ball_reset_n;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;
  logic [2:0] match_state;
  logic       point_pulse;
`ifdef PONG_RALLY_COUNT_EN
  logic [7:0] rally_count;
`endif

  int checks = 0;
  int errors = 0;

  pong_match_controller #(
    .SERVE_TICKS(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .ball_x(ball_x),
    .ball_y(ball_y),
    .p1_paddle_y(p1_paddle_y),
    .p2_paddle_y(p2_paddle_y),
    .ball_reset_n(ball_reset_n),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .winner(winner),
    .match_state(match_state),
`ifdef PONG_RALLY_COUNT_EN
    .rally_count(rally_count),
`endif
    .point_pulse(point_pulse)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From the first SERVE cycle: wait out the serve, move the ball, then
  // drive it into a wall that the given side fails to cover.
  task automatic serve_and_miss(input logic p1_misses, input int e1, input int e2,
                                input int e_state);
    ticks(4);
    chk("serve_to_play", match_state, 2);
    chk("play_ball_run", ball_reset_n, 1);
    ball_x = 6'd20; ball_y = 6'd15;
    tick();
    ball_x = p1_misses ? 6'd0 : 6'd39; ball_y = 6'd0;
    tick();
    chk("miss_point", match_state, 3);
    chk("miss_pulse", point_pulse, 1);
    tick();
    chk("miss_p1", p1_score, e1);
    chk("miss_p2", p2_score, e2);
    chk("miss_next", match_state, e_state);
    chk("miss_pulse_off", point_pulse, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    ball_x = 6'd20; ball_y = 6'd15;
    p1_paddle_y = 6'd10; p2_paddle_y = 6'd27;
    ticks(2);
    chk("rst_state", match_state, 0);
    chk("rst_brn", ball_reset_n, 0);
    chk("rst_p1", p1_score, 0);
    chk("rst_p2", p2_score, 0);
    chk("rst_win", winner, 0);
    chk("rst_pulse", point_pulse, 0);
    reset = 1'b0;
    tick();
    chk("idle_hold", match_state, 0);

    // Start held high for 10 cycles: one SERVE entry, PLAY 4 cycles later.
    start = 1'b1;
    tick();
    chk("serve_entry", match_state, 1);
    chk("serve_brn", ball_reset_n, 0);
    ticks(3);
    chk("serve_last", match_state, 1);
    chk("serve_last_brn", ball_reset_n, 0);
    tick();
    chk("play_entry", match_state, 2);
    chk("play_brn", ball_reset_n, 1);
    ticks(5);
    chk("start_held_play", match_state, 2);
    start = 1'b0;

    // Left paddle hit at row 12 (paddle rows 10..15).
    ball_x = 6'd0; ball_y = 6'd12;
    tick();
    chk("p1_hit_state", match_state, 2);
    chk("p1_hit_pulse", point_pulse, 0);
    chk("p1_hit_s1", p1_score, 0);
    chk("p1_hit_s2", p2_score, 0);
`ifdef PONG_RALLY_COUNT_EN
    chk("rally_one", rally_count, 1);
`endif

    // Left miss at row 16.
    ball_x = 6'd0; ball_y = 6'd16;
    tick();
    chk("p1_miss_point", match_state, 3);
    chk("p1_miss_pulse", point_pulse, 1);
    chk("p1_miss_brn", ball_reset_n, 0);
    tick();
    chk("p1_miss_serve", match_state, 1);
    chk("p1_miss_s2", p2_score, 1);
    chk("p1_miss_pulse_off", point_pulse, 0);
`ifdef PONG_RALLY_COUNT_EN
    chk("rally_clr", rally_count, 0);
`endif

    // Right paddle at 27: end saturates to 29, so row 29 hits, row 26 misses.
    ticks(4);
    chk("play2_entry", match_state, 2);
    ball_x = 6'd39; ball_y = 6'd29;
    tick();
    chk("p2_hit_state", match_state, 2);
    chk("p2_hit_pulse", point_pulse, 0);
    ball_x = 6'd38;
    tick();
    ball_x = 6'd39; ball_y = 6'd26;
    tick();
    chk("p2_miss_point", match_state, 3);
    tick();
    chk("p2_miss_s1", p1_score, 1);
    chk("p2_miss_serve", match_state, 1);

    // Run P1 up to 8, then the ninth point ends the match.
    for (int i = 2; i <= 8; i++) serve_and_miss(1'b0, i, 1, 1);
    serve_and_miss(1'b0, 9, 1, 4);
    chk("win_p1", winner, 1);
    chk("over_brn", ball_reset_n, 0);

    // Ball motion is ignored once the match is over.
    ball_x = 6'd0; ball_y = 6'd5;
    tick();
    chk("over_hold_state", match_state, 4);
    chk("over_hold_s1", p1_score, 9);
    chk("over_hold_pulse", point_pulse, 0);

    // Restart clears scores and winner.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_state", match_state, 1);
    chk("restart_s1", p1_score, 0);
    chk("restart_s2", p2_score, 0);
    chk("restart_win", winner, 0);

    // Build a 3/5 score, then reset mid-SERVE.
    for (int i = 1; i <= 3; i++) serve_and_miss(1'b0, i, 0, 1);
    for (int i = 1; i <= 5; i++) serve_and_miss(1'b1, 3, i, 1);
    ticks(2);
    chk("pre_rst_serve", match_state, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_serve_state", match_state, 0);
    chk("rst_serve_s1", p1_score, 0);
    chk("rst_serve_s2", p2_score, 0);
    chk("rst_serve_brn", ball_reset_n, 0);

    // Build 3/5 again, then reset mid-PLAY.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 3; i++) serve_and_miss(1'b0, i, 0, 1);
    for (int i = 1; i <= 5; i++) serve_and_miss(1'b1, 3, i, 1);
    ticks(4);
    chk("pre_rst_play", match_state, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_play_state", match_state, 0);
    chk("rst_play_s1", p1_score, 0);
    chk("rst_play_s2", p2_score, 0);
    chk("rst_play_brn", ball_reset_n, 0);
    chk("rst_play_win", winner, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
